// File: rtl/rs232_phy_pkg.sv
// Shared types and helpers for the RS-232 byte PHY.
// No logic lives here; state encodings and the bit-period calculation only.
// Both sub-modules derive their bit timing from calc_div so TX and RX always agree.
package rs232_phy_pkg;

  // Smallest bit period (in clocks) that still leaves room for a mid-bit sample.
  localparam int DIV_MIN = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // RX_BREAK parks the receiver after a bad stop bit until the line is idle again.
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  // Bit period rounded to the nearest whole clock.
  function automatic int calc_div(input int freq_hz, input int rate_bps);
    return (freq_hz + rate_bps / 2) / rate_bps;
  endfunction

endpackage

// File: rtl/rs232rx.sv
// 8N1 serial receiver with 2-flop input synchronizer and mid-bit sampling.
// Latency: valid pulses half a bit plus nine bit periods after the synchronized start edge.
// Backpressure: none; valid is a single-cycle pulse and q holds the last good byte.
module rs232rx
  import rs232_phy_pkg::*;
#(
  parameter int frequency = 50_000_000,
  parameter int bps       = 115_200
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       serial_in,
  output logic       valid,
  output logic [7:0] q
);

  localparam int DIV  = calc_div(frequency, bps);
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  if (DIV < DIV_MIN) begin : g_div_too_small
    $error("rs232rx: bit period must be at least 4 clock cycles");
  end

  logic            sync1_q, sync2_q, prev_q;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      q_q, q_d;
  logic            valid_q, valid_d;

  // Synchronizer plus one history flop for edge detection; resets to idle-high so no false start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Receiver state, sample timer, shift register and output byte.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end

  // Start detect, glitch rejection at mid start bit, mid-bit data sampling and stop-bit check.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    q_d     = q_q;
    valid_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (sync2_q) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {sync2_q, shreg_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (sync2_q) begin
            q_d     = shreg_q;
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            state_d = RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_BREAK: begin
        if (sync2_q) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign valid = valid_q;
  assign q     = q_q;

endmodule

// File: rtl/rs232tx.sv
// 8N1 serial transmitter with a single holding/shift stage.
// Latency: line drops to the start bit the cycle after the accepting write; frame lasts 10 bit periods.
// Backpressure: busy is high for the whole frame; writes while busy are silently dropped.
module rs232tx
  import rs232_phy_pkg::*;
#(
  parameter int frequency = 50_000_000,
  parameter int bps       = 115_200
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] d,
  input  logic       we,
  output logic       busy,
  output logic       serial_out
);

  localparam int DIV = calc_div(frequency, bps);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  if (DIV < DIV_MIN) begin : g_div_too_small
    $error("rs232tx: bit period must be at least 4 clock cycles");
  end

  tx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            serial_q, serial_d;
  logic            bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  // State, bit timer, shift register and the registered line driver.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= TX_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      serial_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      serial_q <= serial_d;
    end
  end

  // Frame sequencing: next line level is prepared one cycle ahead so serial_out stays registered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    serial_d = serial_q;
    case (state_q)
      TX_IDLE: begin
        if (we) begin
          state_d  = TX_START;
          shreg_d  = d;
          serial_d = 1'b0;
          cnt_d    = '0;
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_d  = TX_DATA;
          cnt_d    = '0;
          bit_d    = '0;
          serial_d = shreg_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d  = TX_STOP;
            serial_d = 1'b1;
          end else begin
            bit_d    = bit_q + 3'd1;
            shreg_d  = {1'b0, shreg_q[7:1]};
            serial_d = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          state_d = TX_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign busy       = (state_q != TX_IDLE);
  assign serial_out = serial_q;

endmodule

// File: rtl/rs232_phy.sv
// RS-232 byte PHY: independent 8N1 transmitter and receiver on one clock.
// Latency: see rs232tx / rs232rx; the two paths never interact.
// Backpressure: tx_busy gates new sends (extra writes dropped); receive side has none.
module rs232_phy #(
  parameter int frequency = 50_000_000,
  parameter int bps       = 115_200
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       serial_in,
  output logic       serial_out,
  input  logic [7:0] tx_d,
  input  logic       tx_we,
  output logic       tx_busy,
  output logic       rx_valid,
  output logic [7:0] rx_q
);

  rs232tx #(
    .frequency (frequency),
    .bps       (bps)
  ) u_tx (
    .clock      (clock),
    .reset_n    (reset_n),
    .d          (tx_d),
    .we         (tx_we),
    .busy       (tx_busy),
    .serial_out (serial_out)
  );

  rs232rx #(
    .frequency (frequency),
    .bps       (bps)
  ) u_rx (
    .clock     (clock),
    .reset_n   (reset_n),
    .serial_in (serial_in),
    .valid     (rx_valid),
    .q         (rx_q)
  );

endmodule

// File: tb/tb_rs232_phy.sv
// Directed bench for rs232_phy at DIV=10, TX looped to RX unless driven directly.
module tb_rs232_phy;

  localparam int DIV = 10;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       serial_in;
  logic       serial_out;
  logic [7:0] tx_d = 8'h00;
  logic       tx_we = 1'b0;
  logic       tx_busy;
  logic       rx_valid;
  logic [7:0] rx_q;

  logic       loop = 1'b1;
  logic       line_drv = 1'b1;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  int         vt[$];
  logic [7:0] vq[$];

  assign serial_in = loop ? serial_out : line_drv;

  rs232_phy #(
    .frequency (1_000_000),
    .bps       (100_000)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .serial_in  (serial_in),
    .serial_out (serial_out),
    .tx_d       (tx_d),
    .tx_we      (tx_we),
    .tx_busy    (tx_busy),
    .rx_valid   (rx_valid),
    .rx_q       (rx_q)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Log every received byte with the index of the edge that produced it.
  always @(negedge clock) begin
    if (rx_valid) begin
      vq.push_back(rx_q);
      vt.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Called at a negedge; returns at the negedge right after the accepting posedge (cyc == k).
  task automatic tx_send(input logic [7:0] b, output int k);
    tx_d  = b;
    tx_we = 1'b1;
    k     = cyc + 1;
    @(negedge clock);
    tx_we = 1'b0;
    tx_d  = 8'hEE;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (tx_busy && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk(tag, {31'd0, tx_busy}, 32'd0);
  endtask

  // Drives start bit, nbits data bits and (if full) the given stop bit, then idles high.
  task automatic rx_drive(input logic [7:0] b, input logic stop, input int nbits);
    line_drv = 1'b0;
    tick(DIV);
    for (int i = 0; i < nbits; i++) begin
      line_drv = b[i];
      tick(DIV);
    end
    if (nbits == 8) begin
      line_drv = stop;
      tick(DIV);
    end
    line_drv = 1'b1;
  endtask

  function automatic int in_slack(input int delta);
    return (delta >= 97 && delta <= 99) ? 98 : delta;
  endfunction

  initial begin
    int         k, c, base, busy_n, adj;
    int         ks[3];
    logic [7:0] b2b[3];
    logic [9:0] first_v, last_v;

    b2b[0] = 8'hA5;
    b2b[1] = 8'h00;
    b2b[2] = 8'hFF;

    // Reset state
    tick(2);
    chk("rst_serial_out", {31'd0, serial_out}, 32'd1);
    chk("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_q", {24'd0, rx_q}, 32'h00);
    reset_n = 1'b1;
    tick(3);

    // TX 0x55: bit pattern, busy length, loopback receive
    base = vq.size();
    first_v = '0;
    last_v  = '0;
    busy_n  = 0;
    tx_send(8'h55, k);
    for (int j = 0; j < 100; j++) begin
      if (j % 10 == 0) first_v[j / 10] = serial_out;
      if (j % 10 == 9) last_v[j / 10] = serial_out;
      if (tx_busy) busy_n++;
      @(negedge clock);
    end
    chk("tx55_bits_first", {22'd0, first_v}, 32'h2AA);
    chk("tx55_bits_last", {22'd0, last_v}, 32'h2AA);
    chk("tx55_busy_cycles", busy_n, 100);
    chk("tx55_busy_end", {31'd0, tx_busy}, 32'd0);
    tick(10);
    chk("tx55_rx_count", vq.size() - base, 1);
    if (vq.size() > base) begin
      chk("tx55_rx_byte", {24'd0, vq[base]}, 32'h55);
      chk("tx55_rx_delay", in_slack(vt[base] - k), 98);
    end

    // Back-to-back loopback A5, 00, FF
    base = vq.size();
    for (int i = 0; i < 3; i++) begin
      tx_send(b2b[i], ks[i]);
      wait_idle($sformatf("b2b_idle%0d", i));
    end
    tick(20);
    chk("b2b_gap01", ks[1] - ks[0], 101);
    chk("b2b_gap12", ks[2] - ks[1], 101);
    chk("b2b_count", vq.size() - base, 3);
    for (int i = 0; i < 3; i++) begin
      if (vq.size() > base + i) begin
        chk($sformatf("b2b_byte%0d", i), {24'd0, vq[base + i]}, {24'd0, b2b[i]});
        chk($sformatf("b2b_delay%0d", i), in_slack(vt[base + i] - ks[i]), 98);
      end
    end

    // Write while busy is dropped
    base = vq.size();
    tx_send(8'h34, k);
    tick(30);
    tx_d  = 8'h12;
    tx_we = 1'b1;
    tick(1);
    tx_we = 1'b0;
    wait_idle("busy_idle");
    chk("busy_len_34", cyc - k, 100);
    tick(150);
    chk("busy_rx_count", vq.size() - base, 1);
    if (vq.size() > base) chk("busy_rx_byte", {24'd0, vq[base]}, 32'h34);
    chk("busy_line_idle", {31'd0, serial_out}, 32'd1);

    // Direct RX: glitch, framing error, then good frame
    loop     = 1'b0;
    line_drv = 1'b1;
    tick(5);
    base = vq.size();
    line_drv = 1'b0;
    tick(3);
    line_drv = 1'b1;
    tick(40);
    chk("glitch_no_valid", vq.size() - base, 0);
    rx_drive(8'h77, 1'b0, 8);
    tick(40);
    chk("ferr_no_valid", vq.size() - base, 0);
    chk("ferr_rxq_hold", {24'd0, rx_q}, 32'h34);
    c = cyc;
    rx_drive(8'h3C, 1'b1, 8);
    tick(20);
    chk("good3c_count", vq.size() - base, 1);
    if (vq.size() > base) begin
      chk("good3c_byte", {24'd0, vq[base]}, 32'h3C);
      chk("good3c_delay", in_slack(vt[base] - c), 98);
    end

    // Reset mid TX frame
    loop = 1'b1;
    base = vq.size();
    tx_send(8'h0F, k);
    tick(35);
    reset_n = 1'b0;
    #1;
    chk("txrst_serial_out", {31'd0, serial_out}, 32'd1);
    chk("txrst_busy", {31'd0, tx_busy}, 32'd0);
    chk("txrst_rx_q", {24'd0, rx_q}, 32'h00);
    @(negedge clock);
    reset_n = 1'b1;
    tick(200);
    chk("txrst_no_valid", vq.size() - base, 0);
    chk("txrst_line_idle", {31'd0, serial_out}, 32'd1);

    // Reset mid RX frame, then a clean frame
    loop     = 1'b0;
    line_drv = 1'b1;
    tick(5);
    base = vq.size();
    rx_drive(8'hF1, 1'b1, 3);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(150);
    chk("rxrst_no_valid", vq.size() - base, 0);
    c = cyc;
    rx_drive(8'hC3, 1'b1, 8);
    tick(20);
    chk("rxrst_next_count", vq.size() - base, 1);
    if (vq.size() > base) begin
      chk("rxrst_next_byte", {24'd0, vq[base]}, 32'hC3);
      chk("rxrst_next_delay", in_slack(vt[base] - c), 98);
    end
    chk("rxrst_rx_q", {24'd0, rx_q}, 32'hC3);

    // rx_valid never held for two consecutive cycles
    adj = 0;
    for (int i = 1; i < vt.size(); i++) begin
      if (vt[i] == vt[i - 1] + 1) adj++;
    end
    chk("valid_one_cycle", adj, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
